// File: rtl/dmux_4_way_if.sv
// Bus between one producer and the four consumer lanes of dmux_4_way.
// The producer side uses the master modport and the demultiplexer uses the slave modport.
interface dmux_4_way_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] c_out;
  logic [WIDTH-1:0] d_out;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;

  modport master (
    output in, in_valid, sel,
    input  a_out, b_out, c_out, d_out,
    input  a_valid, b_valid, c_valid, d_valid
  );

  modport slave (
    input  in, in_valid, sel,
    output a_out, b_out, c_out, d_out,
    output a_valid, b_valid, c_valid, d_valid
  );
endinterface

// File: rtl/dmux_4_way.sv
// 1-to-4 demultiplexer with registered (REGISTERED=1) or reset-gated combinational outputs.
// Optional per-lane saturating routing counters are enabled by defining DMUX4_STATS_EN.
module dmux_4_way #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dmux_4_way_if.slave      bus
`ifdef DMUX4_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("dmux_4_way: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("dmux_4_way: CNT_W must be at least 1");
  end

  logic [3:0][WIDTH-1:0] route_data_s;
  logic [3:0]            route_valid_s;
  logic [3:0][WIDTH-1:0] lane_data_s;
  logic [3:0]            lane_valid_s;

  // The selected lane carries the word even when in_valid is low; every other lane reads zero.
  always_comb begin
    route_data_s  = '0;
    route_valid_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (bus.sel == 2'(i)) begin
        route_data_s[i]  = bus.in;
        route_valid_s[i] = bus.in_valid;
      end else begin
        route_data_s[i]  = {WIDTH{1'b0}};
        route_valid_s[i] = 1'b0;
      end
    end
  end

  if (REGISTERED != 0) begin : g_registered
    logic [3:0][WIDTH-1:0] data_r;
    logic [3:0]            valid_r;

    // Every edge reloads all lanes, so the old lane clears on the edge where the new lane loads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r  <= '0;
        valid_r <= 4'b0000;
      end else begin
        data_r  <= route_data_s;
        valid_r <= route_valid_s;
      end
    end

    assign lane_data_s  = data_r;
    assign lane_valid_s = valid_r;
  end else begin : g_combinational
    // Combinational path held at zero while reset is asserted.
    always_comb begin
      if (!rst_n) begin
        lane_data_s  = '0;
        lane_valid_s = 4'b0000;
      end else begin
        lane_data_s  = route_data_s;
        lane_valid_s = route_valid_s;
      end
    end
  end

  assign bus.a_out   = lane_data_s[0];
  assign bus.b_out   = lane_data_s[1];
  assign bus.c_out   = lane_data_s[2];
  assign bus.d_out   = lane_data_s[3];
  assign bus.a_valid = lane_valid_s[0];
  assign bus.b_valid = lane_valid_s[1];
  assign bus.c_valid = lane_valid_s[2];
  assign bus.d_valid = lane_valid_s[3];

`ifdef DMUX4_STATS_EN
  logic [3:0][CNT_W-1:0] cnt_r;

  // Saturating routing counters; the clear wins over an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (route_valid_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign cnt_a = cnt_r[0];
  assign cnt_b = cnt_r[1];
  assign cnt_c = cnt_r[2];
  assign cnt_d = cnt_r[3];
`endif

endmodule

// File: tb/tb_dmux_4_way.sv
// Self-checking bench for dmux_4_way: a WIDTH=1 and a WIDTH=8 registered instance plus a
// WIDTH=8 combinational instance, compared against a lane-table reference model.
module tb_dmux_4_way;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmux_4_way_if #(.WIDTH(1)) if1 ();
  dmux_4_way_if #(.WIDTH(8)) if8 ();
  dmux_4_way_if #(.WIDTH(8)) ifc ();

`ifdef DMUX4_STATS_EN
  logic        cnt_clr;
  logic [15:0] cnt1_a, cnt1_b, cnt1_c, cnt1_d;
  logic [1:0]  cnt8_a, cnt8_b, cnt8_c, cnt8_d;
  logic [15:0] cntc_a, cntc_b, cntc_c, cntc_d;
`endif

  dmux_4_way #(.WIDTH(1), .REGISTERED(1)) u_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
`ifdef DMUX4_STATS_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_a   (cnt1_a),
    .cnt_b   (cnt1_b),
    .cnt_c   (cnt1_c),
    .cnt_d   (cnt1_d)
`endif
  );

  dmux_4_way #(.WIDTH(8), .REGISTERED(1), .CNT_W(2)) u_w8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
`ifdef DMUX4_STATS_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_a   (cnt8_a),
    .cnt_b   (cnt8_b),
    .cnt_c   (cnt8_c),
    .cnt_d   (cnt8_d)
`endif
  );

  dmux_4_way #(.WIDTH(8), .REGISTERED(0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
`ifdef DMUX4_STATS_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_a   (cntc_a),
    .cnt_b   (cntc_b),
    .cnt_c   (cntc_c),
    .cnt_d   (cntc_d)
`endif
  );

  // Reference: lane k gets the word iff sel==k, valid only if also in_valid. Packed {data a..d, valid a..d}.
  function automatic logic [7:0] model1(logic d, logic v, logic [1:0] s);
    logic [3:0] dl;
    logic [3:0] vl;
    for (int k = 0; k < 4; k++) begin
      dl[3-k] = (s == 2'(k)) ? d : 1'b0;
      vl[3-k] = (s == 2'(k)) && v;
    end
    return {dl, vl};
  endfunction

  function automatic logic [35:0] model8(logic [7:0] d, logic v, logic [1:0] s);
    logic [7:0] lane [4];
    logic [3:0] vl;
    for (int k = 0; k < 4; k++) begin
      lane[k] = (s == 2'(k)) ? d : 8'h00;
      vl[3-k] = (s == 2'(k)) && v;
    end
    return {lane[0], lane[1], lane[2], lane[3], vl};
  endfunction

  function automatic logic [7:0] obs1();
    return {if1.a_out, if1.b_out, if1.c_out, if1.d_out,
            if1.a_valid, if1.b_valid, if1.c_valid, if1.d_valid};
  endfunction

  function automatic logic [35:0] obs8();
    return {if8.a_out, if8.b_out, if8.c_out, if8.d_out,
            if8.a_valid, if8.b_valid, if8.c_valid, if8.d_valid};
  endfunction

  function automatic logic [35:0] obsc();
    return {ifc.a_out, ifc.b_out, ifc.c_out, ifc.d_out,
            ifc.a_valid, ifc.b_valid, ifc.c_valid, ifc.d_valid};
  endfunction

  task automatic drive1(logic d, logic v, logic [1:0] s);
    if1.in = d; if1.in_valid = v; if1.sel = s;
  endtask

  task automatic drive8(logic [7:0] d, logic v, logic [1:0] s);
    if8.in = d; if8.in_valid = v; if8.sel = s;
    ifc.in = d; ifc.in_valid = v; ifc.sel = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive1(1'b1, 1'b1, 2'b00);
    drive8(8'h01, 1'b1, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs1() !== 8'h00) begin failures++; $display("FAIL reset_w1: got %h expected %h", obs1(), 8'h00); end
    checks++;
    if (obs8() !== 36'h0) begin failures++; $display("FAIL reset_w8: got %h expected %h", obs8(), 36'h0); end
    checks++;
    if (obsc() !== 36'h0) begin failures++; $display("FAIL reset_comb: got %h expected %h", obsc(), 36'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obsc() !== model8(8'h01, 1'b1, 2'b00)) begin
      failures++; $display("FAIL release_comb: got %h expected %h", obsc(), model8(8'h01, 1'b1, 2'b00));
    end
    checks++;
    if (obs1() !== 8'h00) begin failures++; $display("FAIL release_w1_before_edge: got %h expected %h", obs1(), 8'h00); end
    @(posedge clk);
    #1;
    checks++;
    if (obs1() !== 8'b1000_1000) begin failures++; $display("FAIL release_w1_first_edge: got %b expected %b", obs1(), 8'b1000_1000); end
    checks++;
    if (obs8() !== model8(8'h01, 1'b1, 2'b00)) begin
      failures++; $display("FAIL release_w8_first_edge: got %h expected %h", obs8(), model8(8'h01, 1'b1, 2'b00));
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] vec;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      @(negedge clk);
      drive1(vec[2], 1'b1, vec[1:0]);
      @(posedge clk);
      #1;
      checks++;
      if (obs1() !== model1(vec[2], 1'b1, vec[1:0])) begin
        failures++;
        $display("FAIL truth_in%0d_sel%0d: got %b expected %b", vec[2], vec[1:0], obs1(), model1(vec[2], 1'b1, vec[1:0]));
      end
    end
  endtask

  task automatic test_lane_switch();
    logic [1:0] seq [3];
    int         nz;
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive8(8'hA5, 1'b1, seq[i]);
      @(posedge clk);
      #1;
      checks++;
      if (obs8() !== model8(8'hA5, 1'b1, seq[i])) begin
        failures++; $display("FAIL lane_switch_%0d: got %h expected %h", i, obs8(), model8(8'hA5, 1'b1, seq[i]));
      end
      nz = int'(if8.a_out != 8'h00) + int'(if8.b_out != 8'h00) + int'(if8.c_out != 8'h00) + int'(if8.d_out != 8'h00);
      checks++;
      if (nz !== 1) begin failures++; $display("FAIL lane_switch_overlap_%0d: got %0d lanes expected 1", i, nz); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive1(1'b1, 1'b1, 2'b10);
    drive8(8'hA5, 1'b1, 2'b10);
    @(posedge clk);
    #1;
    checks++;
    if (obs1() !== model1(1'b1, 1'b1, 2'b10)) begin
      failures++; $display("FAIL async_pre_w1: got %b expected %b", obs1(), model1(1'b1, 1'b1, 2'b10));
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs1() !== 8'h00) begin failures++; $display("FAIL async_clear_w1: got %b expected %b", obs1(), 8'h00); end
    checks++;
    if (obs8() !== 36'h0) begin failures++; $display("FAIL async_clear_w8: got %h expected %h", obs8(), 36'h0); end
    checks++;
    if (obsc() !== 36'h0) begin failures++; $display("FAIL async_clear_comb: got %h expected %h", obsc(), 36'h0); end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs1() !== model1(1'b1, 1'b1, 2'b10)) begin
      failures++; $display("FAIL async_reload_w1: got %b expected %b", obs1(), model1(1'b1, 1'b1, 2'b10));
    end
  endtask

  task automatic test_comb();
    @(negedge clk);
    drive8(8'h01, 1'b1, 2'b01);
    #1;
    checks++;
    if (ifc.b_out !== 8'h01 || obsc() !== model8(8'h01, 1'b1, 2'b01)) begin
      failures++; $display("FAIL comb_b: got %h expected %h", obsc(), model8(8'h01, 1'b1, 2'b01));
    end
    drive8(8'h3C, 1'b0, 2'b11);
    #1;
    checks++;
    if (obsc() !== model8(8'h3C, 1'b0, 2'b11)) begin
      failures++; $display("FAIL comb_d_invalid: got %h expected %h", obsc(), model8(8'h3C, 1'b0, 2'b11));
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       v;
    logic [1:0] s;
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      v = 1'($urandom);
      s = 2'($urandom);
      @(negedge clk);
      drive8(d, v, s);
      drive1(d[0], v, s);
      #1;
      checks++;
      if (obsc() !== model8(d, v, s)) begin
        failures++; $display("FAIL random_comb_%0d: got %h expected %h", i, obsc(), model8(d, v, s));
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs8() !== model8(d, v, s)) begin
        failures++; $display("FAIL random_w8_%0d: got %h expected %h", i, obs8(), model8(d, v, s));
      end
      checks++;
      if (obs1() !== model1(d[0], v, s)) begin
        failures++; $display("FAIL random_w1_%0d: got %b expected %b", i, obs1(), model1(d[0], v, s));
      end
    end
  endtask

`ifdef DMUX4_STATS_EN
  task automatic test_stats();
    int exp_c;
    @(negedge clk);
    cnt_clr = 1'b1;
    drive8(8'h11, 1'b1, 2'b10);
    @(posedge clk);
    #1;
    checks++;
    if ({cnt8_a, cnt8_b, cnt8_c, cnt8_d} !== 8'h00) begin
      failures++; $display("FAIL stats_clear_all: got %h expected %h", {cnt8_a, cnt8_b, cnt8_c, cnt8_d}, 8'h00);
    end
    exp_c = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      cnt_clr = 1'b0;
      drive8(8'($urandom), 1'b1, 2'b10);
      @(posedge clk);
      #1;
      exp_c = (exp_c < 3) ? exp_c + 1 : 3;
      checks++;
      if (int'(cnt8_c) !== exp_c || {cnt8_a, cnt8_b, cnt8_d} !== 6'b0) begin
        failures++; $display("FAIL stats_count_%0d: got c=%0d expected c=%0d", n, cnt8_c, exp_c);
      end
    end
    @(negedge clk);
    drive8(8'h22, 1'b0, 2'b10);
    @(posedge clk);
    #1;
    checks++;
    if (cnt8_c !== 2'd3) begin failures++; $display("FAIL stats_invalid_hold: got %0d expected 3", cnt8_c); end
    @(negedge clk);
    cnt_clr = 1'b1;
    drive8(8'h33, 1'b1, 2'b10);
    @(posedge clk);
    #1;
    checks++;
    if (cnt8_c !== 2'd0) begin failures++; $display("FAIL stats_clr_priority: got %0d expected 0", cnt8_c); end
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
`ifdef DMUX4_STATS_EN
    cnt_clr = 1'b0;
`endif
    drive1(1'b0, 1'b0, 2'b00);
    drive8(8'h00, 1'b0, 2'b00);
    test_reset();
    test_truth_table();
    test_lane_switch();
    test_async_reset();
    test_comb();
    test_random();
`ifdef DMUX4_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
